// File: rtl/neuron_stream_feeder.sv
// Walks NUM_NEURONS x CHUNKS operand words from two ROMs into a mac_acc_sigmoid node, waits
// out its pipeline, and returns each sigmoid result on a valid/ready port tagged by neuron.
module neuron_stream_feeder #(
    parameter int DATA_W      = 128,
    parameter int OUT_W       = 8,
    parameter int ADDR_W      = 6,
    parameter int CHUNKS      = 4,
    parameter int NUM_NEURONS = 10,
    parameter int PIPE_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic [DATA_W-1:0] w_rdata,
    output logic              mac_rst,
    output logic [DATA_W-1:0] mac_p,
    output logic [DATA_W-1:0] mac_w,
    input  logic [OUT_W-1:0]  mac_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [3:0]        res_index
);
    localparam int CNT_MAX = (CHUNKS > PIPE_LAT + 1) ? CHUNKS : PIPE_LAT + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, EMIT} state_t;

    state_t           state;
    logic [3:0]       neuron;
    logic [CNT_W-1:0] chunk;   // FEED chunk index, reused as the WAIT cycle count

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mac_rst   <= 1'b1;
            mac_p     <= '0;
            mac_w     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_index <= '0;
            neuron    <= '0;
            chunk     <= '0;
        end else begin
            done  <= 1'b0;
            mac_p <= '0;
            mac_w <= '0;
            case (state)
                IDLE: begin
                    mac_rst <= 1'b1;
                    if (start) begin
                        state    <= CLEAR;
                        neuron   <= '0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                CLEAR: begin
                    state   <= FEED;
                    chunk   <= '0;
                    mac_rst <= 1'b0;
                    if (CHUNKS > 1) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end else begin
                        mem_rd <= 1'b0;
                    end
                end
                FEED: begin
                    // ROM data returned this cycle belongs to the word addressed one cycle earlier
                    mac_p <= p_rdata;
                    mac_w <= w_rdata;
                    if (chunk == CNT_W'(CHUNKS - 1)) begin
                        state  <= WAIT;
                        chunk  <= '0;
                        mem_rd <= 1'b0;
                    end else begin
                        chunk <= chunk + CNT_W'(1);
                        if (32'(chunk) + 2 < CHUNKS) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end else begin
                            mem_rd <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (chunk == CNT_W'(PIPE_LAT)) begin
                        state     <= EMIT;
                        res_data  <= mac_dout;
                        res_index <= neuron;
                        res_valid <= 1'b1;
                    end else begin
                        chunk <= chunk + CNT_W'(1);
                    end
                end
                EMIT: begin
                    // accumulator is left untouched here so mac_dout stays valid while stalled
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        mac_rst   <= 1'b1;
                        if (neuron == 4'(NUM_NEURONS - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= CLEAR;
                            neuron   <= neuron + 4'd1;
                            mem_rd   <= 1'b1;
                            mem_addr <= ADDR_W'((32'(neuron) + 1) * CHUNKS);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_stream_feeder.sv
// Drives neuron_stream_feeder against behavioural ROMs and MAC/sigmoid nodes; results are
// predicted directly from ROM contents, timing from the documented edge counts.
module tb_neuron_stream_feeder;
    localparam int DW = 128, OW = 8, AW = 6, C = 4, NN = 10, PL = 2;
    localparam int LAT = C + PL + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int e0;

    // main instance (default parameters)
    logic          start, busy, done, mem_rd, mac_rst, res_valid, res_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] p_rdata, w_rdata, mac_p, mac_w;
    logic [OW-1:0] mac_dout, res_data;
    logic [3:0]    res_index;

    // corner instance: one chunk per neuron, zero-latency node
    logic          start_c, busy_c, done_c, mem_rd_c, mac_rst_c, res_valid_c, ready_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] p_rdata_c, w_rdata_c, mac_p_c, mac_w_c;
    logic [OW-1:0] mac_dout_c, res_data_c;
    logic [3:0]    res_index_c;

    neuron_stream_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .p_rdata(p_rdata), .w_rdata(w_rdata),
        .mac_rst(mac_rst), .mac_p(mac_p), .mac_w(mac_w), .mac_dout(mac_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
    );

    neuron_stream_feeder #(.CHUNKS(1), .PIPE_LAT(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .mem_rd(mem_rd_c), .mem_addr(mem_addr_c), .p_rdata(p_rdata_c), .w_rdata(w_rdata_c),
        .mac_rst(mac_rst_c), .mac_p(mac_p_c), .mac_w(mac_w_c), .mac_dout(mac_dout_c),
        .res_valid(res_valid_c), .res_ready(ready_c), .res_data(res_data_c), .res_index(res_index_c)
    );

    logic [DW-1:0] p_rom [64];
    logic [DW-1:0] w_rom [64];

    function automatic int dot(input logic [DW-1:0] p, input logic [DW-1:0] w);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(p[8*i +: 8]) * int'(w[8*i +: 8]);
        return s;
    endfunction

    function automatic logic [7:0] sig(input int a);
        return 8'((a * 255) / (a + 4096));
    endfunction

    function automatic logic [7:0] gold(input int n, input int ch);
        int s = 0;
        for (int c = 0; c < ch; c++) s += dot(p_rom[n*ch + c], w_rom[n*ch + c]);
        return sig(s);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            p_rdata <= p_rom[mem_addr];
            w_rdata <= w_rom[mem_addr];
        end
        if (mem_rd_c) begin
            p_rdata_c <= p_rom[mem_addr_c];
            w_rdata_c <= w_rom[mem_addr_c];
        end
    end

    // node models: registered accumulate then registered sigmoid (2 edges), and a combinational one
    int         acc   = 0;
    int         acc_c = 0;
    logic [7:0] dout_r;
    always @(posedge clk) begin
        acc    <= mac_rst ? 0 : acc + dot(mac_p, mac_w);
        dout_r <= sig(acc);
        acc_c  <= mac_rst_c ? 0 : acc_c + dot(mac_p_c, mac_w_c);
    end
    assign mac_dout   = dout_r;
    assign mac_dout_c = sig(acc_c + dot(mac_p_c, mac_w_c));

    int addr_log[$];
    int log_c[$];
    int rst_runs[$];
    int nz_cnt, nz_first, done_cnt, rst_run, rd_bad_c;

    always @(negedge clk) begin
        if (mem_rd) addr_log.push_back(int'(mem_addr));
        if (mac_p != '0 || mac_w != '0) begin
            if (nz_cnt == 0) nz_first = cyc;
            nz_cnt++;
        end
        if (done) done_cnt++;
        if (mac_rst) rst_run++;
        else if (rst_run > 0) begin
            rst_runs.push_back(rst_run);
            rst_run = 0;
        end
        if (mem_rd_c) begin
            log_c.push_back(int'(mem_addr_c));
            if (!(mac_rst_c && busy_c)) rd_bad_c++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_monitors();
        addr_log.delete();
        log_c.delete();
        rst_runs.delete();
        nz_cnt   = 0;
        nz_first = -1;
        done_cnt = 0;
        rd_bad_c = 0;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 64; a++)
            for (int l = 0; l < 16; l++) begin
                p_rom[a][8*l +: 8] = 8'($urandom_range(0, 15));
                w_rom[a][8*l +: 8] = 8'($urandom_range(0, 15));
            end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic check_addr_seq(input string tag);
        int bad = 0;
        foreach (addr_log[i]) if (addr_log[i] != i) bad++;
        chk({tag, "_count"}, addr_log.size(), NN * C);
        chk({tag, "_gaps"}, bad, 0);
    endtask

    // Collects `count` results; hold=1 keeps res_ready high, otherwise ready pulses after a stall.
    task automatic run_neurons(input bit hold, input int stall_idx, input int start_idx, input int count);
        int prev = e0;
        for (int n = 0; n < count; n++) begin
            int b = 0;
            while (!res_valid && b < 100) begin
                @(negedge clk);
                b++;
            end
            chk("valid_timeout", res_valid, 1);
            if (!res_valid) return;
            chk("valid_rise", cyc, prev + LAT);
            chk("res_index", res_index, n);
            chk("res_data", res_data, gold(n, C));
            if (!hold) begin
                int stall = (n == stall_idx) ? 5 : $urandom_range(0, 2);
                logic [7:0] d0 = res_data;
                logic [3:0] i0 = res_index;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("stall_hold", {res_valid, res_index, res_data}, {1'b1, i0, d0});
                    chk("stall_quiet", {mem_rd, mac_rst}, 2'b00);
                end
                res_ready = 1'b1;
            end
            @(negedge clk);
            if (!hold) res_ready = 1'b0;
            prev = cyc;
            if (n == NN - 1) chk("done_pulse", {done, busy, res_valid}, 3'b100);
            else chk("next_read", {mem_rd, mac_rst, busy, res_valid, mem_addr},
                     {4'b1110, AW'((n + 1) * C)});
            if (n + 1 == start_idx) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_on_restart", busy, 1);
            end
        end
        if (count == NN) begin
            @(negedge clk);
            chk("done_width", done, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, b, bad;
        rst = 1'b1; start = 1'b0; res_ready = 1'b0; start_c = 1'b0; ready_c = 1'b0;
        reset_monitors();
        rst_run = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, mem_rd, res_valid, mac_rst}, 5'b00001);
        chk("rst_addr", mem_addr, 0);
        chk("rst_mac_p", {|mac_p, |mac_w}, 2'b00);
        chk("rst_res", {res_index, res_data}, 0);
        chk("rst_corner", {busy_c, res_valid_c, mac_rst_c}, 3'b001);
        rst = 1'b0;
        @(negedge clk);

        // full run, ready held high
        fill_random();
        reset_monitors();
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_start();
        run_neurons(1'b1, -1, -1, NN);
        check_addr_seq("run1_addr");
        chk("run1_done_cnt", done_cnt, 1);
        bad = 0;
        for (int i = 1; i < rst_runs.size(); i++) if (rst_runs[i] != 1) bad++;
        chk("mac_rst_runs", rst_runs.size(), NN);
        chk("mac_rst_width", bad, 0);

        // backpressure on neuron 3, start re-asserted during neuron 2
        fill_random();
        reset_monitors();
        res_ready = 1'b0;
        @(negedge clk);
        do_start();
        run_neurons(1'b0, 3, 2, NN);
        check_addr_seq("run2_addr");
        chk("run2_done_cnt", done_cnt, 1);

        // operand isolation: only neuron 1's words are nonzero
        for (int a = 0; a < 64; a++) begin
            p_rom[a] = (a >= 4 && a < 8) ? {16{8'h01}} : '0;
            w_rom[a] = p_rom[a];
        end
        reset_monitors();
        res_ready = 1'b1;
        @(negedge clk);
        do_start();
        run_neurons(1'b1, -1, -1, NN);
        chk("iso_nonzero_cycles", nz_cnt, C);
        chk("iso_first_load", nz_first, e0 + LAT + 3);
        chk("iso_result", gold(1, C), 8'd3);

        // reset during WAIT of neuron 5, then replay
        fill_random();
        reset_monitors();
        @(negedge clk);
        do_start();
        run_neurons(1'b1, -1, -1, 5);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {busy, res_valid, done, mem_rd, mac_rst}, 5'b00001);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid || done || busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        chk("abort_no_done", done_cnt, 0);
        reset_monitors();
        do_start();
        run_neurons(1'b1, -1, -1, NN);
        check_addr_seq("replay_addr");

        // corner instance: CHUNKS=1, PIPE_LAT=0
        fill_random();
        reset_monitors();
        ready_c = 1'b1;
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        prev = cyc;
        for (int n = 0; n < NN; n++) begin
            b = 0;
            while (!res_valid_c && b < 50) begin
                @(negedge clk);
                b++;
            end
            chk("c_valid_timeout", res_valid_c, 1);
            if (!res_valid_c) break;
            chk("c_valid_rise", cyc, prev + 3);
            chk("c_res_index", res_index_c, n);
            chk("c_res_data", res_data_c, gold(n, 1));
            @(negedge clk);
            prev = cyc;
        end
        chk("c_done", {done_c, busy_c}, 2'b10);
        bad = 0;
        foreach (log_c[i]) if (log_c[i] != i) bad++;
        chk("c_addr_count", log_c.size(), NN);
        chk("c_addr_seq", bad, 0);
        chk("c_rd_only_clear", rd_bad_c, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
